// File: rtl/axi_lite_reg_file_multi_port_if.sv
// AXI4-Lite interface bundle for the multi-port register file control port.
// The master modport drives requests; the slave modport answers them.
interface ifc_axi4_lite #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi_lite_reg_file_multi_port.sv
// AXI4-Lite register file with NUM_HW_PORTS hardware write ports sharing one
// bank of NUM_REGISTERS registers. Per-register read-only and W1C modes,
// byte strobes, fixed write priority and a configurable read pipeline.
// Optional feature macro: AXI_REG_FILE_ERR_RESP_EN (SLVERR on out-of-range
// accesses; otherwise every response is OKAY).
module axi_lite_reg_file_multi_port #(
    parameter int                          AXI_ADDR_WIDTH   = 32,
    parameter int                          AXI_DATA_WIDTH   = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0]   AXI_BASE_ADDR    = '0,
    parameter int                          REGISTER_WIDTH   = 32,
    parameter int                          NUM_REGISTERS    = 16,
    parameter int                          NUM_HW_PORTS     = 2,
    parameter int                          ADD_READ_LATENCY = 0,
    parameter logic [NUM_REGISTERS-1:0]    RO_MASK          = '0,
    parameter logic [NUM_REGISTERS-1:0]    W1C_MASK         = '0
) (
    input  logic                                               clk,
    input  logic                                               rst,
    ifc_axi4_lite.slave                                        if_axi_ctrl,
    input  logic [NUM_HW_PORTS*NUM_REGISTERS-1:0]              i_hw_write_req,
    input  logic [NUM_HW_PORTS*NUM_REGISTERS*REGISTER_WIDTH-1:0] i_hw_write_data,
    output logic [NUM_REGISTERS*REGISTER_WIDTH-1:0]            o_reg_data,
    output logic [NUM_REGISTERS-1:0]                           o_axi_write_trigger
);
    localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;
    localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
    localparam int IDX_W      = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1;
    localparam int NSTG       = ADD_READ_LATENCY + 1;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_e;

    function automatic logic addr_in_range(input logic [AXI_ADDR_WIDTH-1:0] addr);
        return (addr >= AXI_BASE_ADDR) &&
               (((addr - AXI_BASE_ADDR) >> ADDR_LSB) < AXI_ADDR_WIDTH'(NUM_REGISTERS));
    endfunction

    function automatic logic [IDX_W-1:0] addr_index(input logic [AXI_ADDR_WIDTH-1:0] addr);
        return IDX_W'((addr - AXI_BASE_ADDR) >> ADDR_LSB);
    endfunction

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wstate_e                   w_state_q, w_state_d;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
    logic [AXI_DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0]     wstrb_q;
    logic [1:0]                bresp_q;
    logic                      aw_hs, w_hs, wr_apply, wr_hit_any, wr_err;
    logic [AXI_ADDR_WIDTH-1:0] wr_addr;
    logic [AXI_DATA_WIDTH-1:0] wr_data;
    logic [STRB_WIDTH-1:0]     wr_strb;
    logic [IDX_W-1:0]          wr_idx;
    logic [REGISTER_WIDTH-1:0] wr_bit_mask;
    logic [REGISTER_WIDTH-1:0] wr_data_reg;
    logic                      unused_wr_bits;

    assign aw_hs = if_axi_ctrl.awvalid && if_axi_ctrl.awready;
    assign w_hs  = if_axi_ctrl.wvalid  && if_axi_ctrl.wready;

    // A channel latched in an earlier cycle supplies its stored value;
    // otherwise the live bus value is used for same-cycle completion.
    assign wr_addr  = (w_state_q == W_HAVE_AW) ? awaddr_q : if_axi_ctrl.awaddr;
    assign wr_data  = (w_state_q == W_HAVE_W)  ? wdata_q  : if_axi_ctrl.wdata;
    assign wr_strb  = (w_state_q == W_HAVE_W)  ? wstrb_q  : if_axi_ctrl.wstrb;
    assign wr_apply = (aw_hs || (w_state_q == W_HAVE_AW)) && (w_hs || (w_state_q == W_HAVE_W));
    assign wr_hit_any  = wr_apply && addr_in_range(wr_addr);
    assign wr_idx      = addr_index(wr_addr);
    assign wr_data_reg = wr_data[REGISTER_WIDTH-1:0];
    assign unused_wr_bits = ^{wr_data, wr_strb};

`ifdef AXI_REG_FILE_ERR_RESP_EN
    assign wr_err = !addr_in_range(wr_addr);
`else
    assign wr_err = 1'b0;
`endif

    // Expand byte strobes to a per-bit write mask over the register width
    always_comb begin
        wr_bit_mask = '0;
        for (int b = 0; b < REGISTER_WIDTH; b++) begin
            wr_bit_mask[b] = wr_strb[b / 8];
        end
    end

    // Write FSM next state and channel readiness
    always_comb begin
        w_state_d          = w_state_q;
        if_axi_ctrl.awready = 1'b0;
        if_axi_ctrl.wready  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if_axi_ctrl.awready = 1'b1;
                if_axi_ctrl.wready  = 1'b1;
                if (aw_hs && w_hs) w_state_d = W_RESP;
                else if (aw_hs)    w_state_d = W_HAVE_AW;
                else if (w_hs)     w_state_d = W_HAVE_W;
            end
            W_HAVE_AW: begin
                if_axi_ctrl.wready = 1'b1;
                if (w_hs) w_state_d = W_RESP;
            end
            W_HAVE_W: begin
                if_axi_ctrl.awready = 1'b1;
                if (aw_hs) w_state_d = W_RESP;
            end
            W_RESP: begin
                if (if_axi_ctrl.bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write FSM state, channel latches and response code
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= 2'b00;
        end else begin
            w_state_q <= w_state_d;
            if (aw_hs) awaddr_q <= if_axi_ctrl.awaddr;
            if (w_hs) begin
                wdata_q <= if_axi_ctrl.wdata;
                wstrb_q <= if_axi_ctrl.wstrb;
            end
            if (wr_apply) bresp_q <= wr_err ? 2'b10 : 2'b00;
        end
    end

    assign if_axi_ctrl.bvalid = (w_state_q == W_RESP);
    assign if_axi_ctrl.bresp  = bresp_q;

    // ------------------------------------------------------------------
    // Register bank
    // ------------------------------------------------------------------
    logic [REGISTER_WIDTH-1:0] reg_view [NUM_REGISTERS];

    for (genvar gi = 0; gi < NUM_REGISTERS; gi++) begin : g_reg
        logic [REGISTER_WIDTH-1:0] val_q, val_d;
        logic [REGISTER_WIDTH-1:0] hw_win, hw_or;
        logic                      hw_any, axi_hit, trig_q;

        // Resolve hardware and AXI writes; hardware wins for RW/RO, while
        // W1C clears first and then sets so simultaneous set beats clear.
        always_comb begin
            hw_any  = 1'b0;
            hw_win  = '0;
            hw_or   = '0;
            for (int p = NUM_HW_PORTS - 1; p >= 0; p--) begin
                if (i_hw_write_req[p*NUM_REGISTERS + gi]) begin
                    hw_any = 1'b1;
                    hw_win = i_hw_write_data[(p*NUM_REGISTERS + gi)*REGISTER_WIDTH +: REGISTER_WIDTH];
                    hw_or  = hw_or | hw_win;
                end
            end
            axi_hit = wr_hit_any && (wr_idx == IDX_W'(gi));
            val_d   = val_q;
            if (W1C_MASK[gi]) begin
                if (axi_hit) val_d = val_q & ~(wr_data_reg & wr_bit_mask);
                val_d = val_d | hw_or;
            end else begin
                if (axi_hit && !RO_MASK[gi])
                    val_d = (val_q & ~wr_bit_mask) | (wr_data_reg & wr_bit_mask);
                if (hw_any) val_d = hw_win;
            end
        end

        // Register storage and the one-cycle AXI write trigger
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                val_q  <= '0;
                trig_q <= 1'b0;
            end else begin
                val_q  <= val_d;
                trig_q <= axi_hit;
            end
        end

        assign reg_view[gi]                                     = val_q;
        assign o_reg_data[gi*REGISTER_WIDTH +: REGISTER_WIDTH]  = val_q;
        assign o_axi_write_trigger[gi]                          = trig_q;
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    logic                      rd_busy_q, ar_hs, rd_in_range, rd_err;
    logic [AXI_DATA_WIDTH-1:0] rd_sample;
    logic [NSTG-1:0]           stg_valid_q, stg_err_q, in_valid, in_err;
    logic [AXI_DATA_WIDTH-1:0] stg_data_q [NSTG];
    logic [AXI_DATA_WIDTH-1:0] in_data    [NSTG];

    assign if_axi_ctrl.arready = !rd_busy_q;
    assign ar_hs       = if_axi_ctrl.arvalid && !rd_busy_q;
    assign rd_in_range = addr_in_range(if_axi_ctrl.araddr);
    assign rd_sample   = rd_in_range ? AXI_DATA_WIDTH'(reg_view[addr_index(if_axi_ctrl.araddr)]) : '0;

`ifdef AXI_REG_FILE_ERR_RESP_EN
    assign rd_err = !rd_in_range;
`else
    assign rd_err = 1'b0;
`endif

    // Feed each pipeline stage from the sample or the previous stage
    always_comb begin
        in_valid   = '0;
        in_err     = '0;
        in_valid[0] = ar_hs;
        in_err[0]   = rd_err;
        in_data[0]  = rd_sample;
        for (int s = 1; s < NSTG; s++) begin
            in_valid[s] = stg_valid_q[s-1];
            in_err[s]   = stg_err_q[s-1];
            in_data[s]  = stg_data_q[s-1];
        end
    end

    // Read pipeline; the last stage is the R channel and holds until rready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_busy_q   <= 1'b0;
            stg_valid_q <= '0;
            stg_err_q   <= '0;
            for (int s = 0; s < NSTG; s++) stg_data_q[s] <= '0;
        end else begin
            if (ar_hs)
                rd_busy_q <= 1'b1;
            else if (stg_valid_q[NSTG-1] && if_axi_ctrl.rready)
                rd_busy_q <= 1'b0;
            for (int s = 0; s < NSTG - 1; s++) begin
                stg_valid_q[s] <= in_valid[s];
                stg_err_q[s]   <= in_err[s];
                stg_data_q[s]  <= in_data[s];
            end
            if (stg_valid_q[NSTG-1] && if_axi_ctrl.rready) begin
                stg_valid_q[NSTG-1] <= 1'b0;
            end else if (in_valid[NSTG-1]) begin
                stg_valid_q[NSTG-1] <= 1'b1;
                stg_err_q[NSTG-1]   <= in_err[NSTG-1];
                stg_data_q[NSTG-1]  <= in_data[NSTG-1];
            end
        end
    end

    assign if_axi_ctrl.rvalid = stg_valid_q[NSTG-1];
    assign if_axi_ctrl.rdata  = stg_data_q[NSTG-1];
    assign if_axi_ctrl.rresp  = stg_err_q[NSTG-1] ? 2'b10 : 2'b00;
endmodule

// File: tb/tb_axi_lite_reg_file_multi_port.sv
// Self-checking bench: directed scenarios plus randomized AXI/hardware
// traffic compared against an array-based behavioural model.
module tb_axi_lite_reg_file_multi_port;
    localparam int          NR   = 8;
    localparam int          NP   = 2;
    localparam int          LAT  = 2;
    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam logic [NR-1:0] RO  = 8'h01;
    localparam logic [NR-1:0] W1C = 8'h20;
`ifdef AXI_REG_FILE_ERR_RESP_EN
    localparam logic [1:0] ERR_RESP = 2'b10;
`else
    localparam logic [1:0] ERR_RESP = 2'b00;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ifc_axi4_lite #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();
    logic [NP*NR-1:0]    hw_req;
    logic [NP*NR*32-1:0] hw_data;
    logic [NR*32-1:0]    reg_data;
    logic [NR-1:0]       trig;

    axi_lite_reg_file_multi_port #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_BASE_ADDR(BASE),
        .REGISTER_WIDTH(32), .NUM_REGISTERS(NR), .NUM_HW_PORTS(NP),
        .ADD_READ_LATENCY(LAT), .RO_MASK(RO), .W1C_MASK(W1C)
    ) u_dut (
        .clk                 (clk),
        .rst                 (rst),
        .if_axi_ctrl         (axi),
        .i_hw_write_req      (hw_req),
        .i_hw_write_data     (hw_data),
        .o_reg_data          (reg_data),
        .o_axi_write_trigger (trig)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural model state
    logic [31:0] model [NR];
    logic        ap_en;
    logic [31:0] ap_addr, ap_data;
    logic [3:0]  ap_strb;
    bit          hw_rand_en;
    bit          coll_en;
    logic [NP*NR-1:0]    coll_req;
    logic [NP*NR*32-1:0] coll_data;

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) / 4) < NR);
    endfunction

    function automatic logic [31:0] areg(input int r);
        return BASE + 32'(r) * 4;
    endfunction

    // Advance one clock: predict the next register state from the inputs
    // being driven, then compare registers and triggers after the edge.
    task automatic tick();
        logic [31:0]      nxt [NR];
        logic [NR-1:0]    nt;
        logic [NR*32-1:0] flat;
        nt = '0;
        for (int r = 0; r < NR; r++) begin
            bit          hit, any;
            logic [31:0] strobed, merged, win, hwor, cur;
            cur = model[r];
            hit = ap_en && in_rng(ap_addr) && (((ap_addr - BASE) / 4) == r);
            if (hit) nt[r] = 1'b1;
            strobed = 32'h0;
            merged  = cur;
            for (int k = 0; k < 4; k++) begin
                if (ap_strb[k]) begin
                    strobed[8*k +: 8] = ap_data[8*k +: 8];
                    merged[8*k +: 8]  = ap_data[8*k +: 8];
                end
            end
            any = 0; win = 0; hwor = 0;
            for (int p = 0; p < NP; p++) begin
                if (hw_req[p*NR + r]) begin
                    if (!any) win = hw_data[(p*NR + r)*32 +: 32];
                    any  = 1;
                    hwor = hwor | hw_data[(p*NR + r)*32 +: 32];
                end
            end
            if (W1C[r])          nxt[r] = (cur & ~(hit ? strobed : 32'h0)) | hwor;
            else if (any)        nxt[r] = win;
            else if (hit && !RO[r]) nxt[r] = merged;
            else                 nxt[r] = cur;
        end
        @(posedge clk);
        #1;
        for (int r = 0; r < NR; r++) begin
            model[r] = nxt[r];
            flat[r*32 +: 32] = nxt[r];
        end
        check("regs", reg_data, flat);
        check("trigger", trig, nt);
        ap_en  = 1'b0;
        hw_req = '0;
        if (hw_rand_en) begin
            for (int i = 0; i < NP*NR; i++) hw_data[i*32 +: 32] = $urandom;
            for (int p = 0; p < NP; p++)
                if ($urandom_range(0, 2) == 0) hw_req[p*NR + $urandom_range(0, NR-1)] = 1'b1;
        end
    endtask

    task automatic mark_apply(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        ap_en = 1'b1; ap_addr = addr; ap_data = data; ap_strb = strb;
        if (coll_en) begin
            hw_req  = coll_req;
            hw_data = coll_data;
        end
    endtask

    // order: 0 = AW and W together, 1 = AW first, 2 = W first
    task automatic axi_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int order, input int gap, input int bhold);
        logic [1:0] exp_resp;
        exp_resp = in_rng(addr) ? 2'b00 : ERR_RESP;
        axi.awaddr = addr; axi.wdata = data; axi.wstrb = strb;
        if (order == 0) begin
            check("wr_ready_both", {axi.awready, axi.wready}, 2'b11);
            axi.awvalid = 1'b1; axi.wvalid = 1'b1;
            mark_apply(addr, data, strb);
            tick();
            axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        end else if (order == 1) begin
            check("awready", axi.awready, 1'b1);
            axi.awvalid = 1'b1;
            tick();
            axi.awvalid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                check("aw_held", {axi.awready, axi.wready}, 2'b01);
                tick();
            end
            check("wready", axi.wready, 1'b1);
            axi.wvalid = 1'b1;
            mark_apply(addr, data, strb);
            tick();
            axi.wvalid = 1'b0;
        end else begin
            check("wready", axi.wready, 1'b1);
            axi.wvalid = 1'b1;
            tick();
            axi.wvalid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                check("w_held", {axi.awready, axi.wready}, 2'b10);
                tick();
            end
            check("awready", axi.awready, 1'b1);
            axi.awvalid = 1'b1;
            mark_apply(addr, data, strb);
            tick();
            axi.awvalid = 1'b0;
        end
        check("b_state", {axi.bvalid, axi.awready, axi.wready}, 3'b100);
        check("bresp", axi.bresp, exp_resp);
        for (int h = 0; h < bhold; h++) begin
            tick();
            check("b_hold", {axi.bvalid, axi.bresp}, {1'b1, exp_resp});
        end
        axi.bready = 1'b1;
        tick();
        axi.bready = 1'b0;
        check("b_done", {axi.bvalid, axi.awready, axi.wready}, 3'b011);
        $display("[TB] write addr=%h data=%h strb=%b order=%0d resp=%0d", addr, data, strb, order, exp_resp);
    endtask

    task automatic axi_rd(input logic [31:0] addr, input int hold);
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        int          lat;
        exp_d = in_rng(addr) ? model[(addr - BASE) / 4] : 32'h0;
        exp_r = in_rng(addr) ? 2'b00 : ERR_RESP;
        check("arready", axi.arready, 1'b1);
        axi.araddr = addr; axi.arvalid = 1'b1;
        tick();
        axi.arvalid = 1'b0;
        lat = 1;
        while (!axi.rvalid && lat < 10) begin
            check("ar_busy", axi.arready, 1'b0);
            tick();
            lat++;
        end
        if (!axi.rvalid) begin
            check("rvalid_timeout", axi.rvalid, 1'b1);
            return;
        end
        check("r_latency", lat, 1 + LAT);
        check("rdata", axi.rdata, exp_d);
        check("rresp", axi.rresp, exp_r);
        for (int h = 0; h < hold; h++) begin
            tick();
            check("r_hold", {axi.rvalid, axi.arready}, 2'b10);
            check("rdata_hold", axi.rdata, exp_d);
        end
        axi.rready = 1'b1;
        tick();
        axi.rready = 1'b0;
        check("r_done", {axi.rvalid, axi.arready}, 2'b01);
        $display("[TB] read  addr=%h data=%h resp=%0d", addr, exp_d, exp_r);
    endtask

    initial begin
        rst = 1'b1;
        axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
        axi.bready = 1'b0; axi.araddr = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
        hw_req = '0; hw_data = '0; ap_en = 1'b0; ap_addr = '0; ap_data = '0; ap_strb = '0;
        hw_rand_en = 0; coll_en = 0; coll_req = '0; coll_data = '0;
        for (int r = 0; r < NR; r++) model[r] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_regs", reg_data, '0);
        check("rst_ready", {axi.awready, axi.wready, axi.arready}, 3'b111);
        check("rst_valid", {axi.bvalid, axi.rvalid}, 2'b00);
        check("rst_resp", {axi.bresp, axi.rresp, axi.rdata}, '0);
        check("rst_trig", trig, '0);
        rst = 1'b0;

        // Strobed write with AW one cycle ahead of W
        axi_wr(areg(3), 32'h1122_3344, 4'hF, 0, 0, 0);
        axi_wr(areg(3), 32'hDEAD_BEEF, 4'b0101, 1, 0, 1);
        check("strobe_reg3", reg_data[3*32 +: 32], 32'h11AD_33EF);

        // W1C clear colliding with a hardware sticky set
        hw_req[0*NR + 5] = 1'b1;
        hw_data[(0*NR + 5)*32 +: 32] = 32'hFF;
        tick();
        check("w1c_set", reg_data[5*32 +: 32], 32'hFF);
        coll_en = 1; coll_req = '0; coll_data = '0;
        coll_req[1*NR + 5] = 1'b1;
        coll_data[(1*NR + 5)*32 +: 32] = 32'h01;
        axi_wr(areg(5), 32'h0F, 4'hF, 0, 0, 0);
        check("w1c_collide", reg_data[5*32 +: 32], 32'hF1);

        // Two hardware ports and AXI all hit RW reg 2; port 0 wins
        coll_req = '0; coll_data = '0;
        coll_req[0*NR + 2] = 1'b1; coll_data[(0*NR + 2)*32 +: 32] = 32'hA;
        coll_req[1*NR + 2] = 1'b1; coll_data[(1*NR + 2)*32 +: 32] = 32'hB;
        axi_wr(areg(2), 32'hC, 4'hF, 2, 1, 0);
        check("hw_priority", reg_data[2*32 +: 32], 32'hA);
        coll_en = 0;

        // Pipelined read with back-pressure
        axi_wr(areg(7), 32'h55, 4'hF, 0, 0, 0);
        axi_rd(areg(7), 3);

        // Read-only register ignores AXI data but still triggers
        axi_wr(areg(0), 32'h1234, 4'hF, 0, 0, 0);
        check("ro_reg0", reg_data[0*32 +: 32], 32'h0);

        // Out-of-range accesses above and below the window
        axi_rd(BASE + NR*4, 0);
        axi_rd(BASE - 4, 1);
        axi_wr(BASE + NR*4, 32'hFFFF_FFFF, 4'hF, 1, 1, 0);

        // Randomized traffic with background hardware writes
        hw_rand_en = 1;
        for (int it = 0; it < 60; it++) begin
            int r;
            r = $urandom_range(0, NR + 1);
            if ($urandom_range(0, 1) == 0)
                axi_wr(areg(r), $urandom, 4'($urandom_range(0, 15)),
                       $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
            else
                axi_rd(areg(r), $urandom_range(0, 3));
        end
        hw_rand_en = 0;
        tick();

        // Reset in the middle of a write drops it without a response
        axi.awaddr = areg(1); axi.awvalid = 1'b1;
        tick();
        axi.awvalid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_ready", {axi.bvalid, axi.awready, axi.wready, axi.arready}, 4'b0111);
        check("midrst_regs", reg_data, '0);
        for (int r = 0; r < NR; r++) model[r] = 32'h0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        axi.wdata = 32'h77; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
        tick();
        axi.wvalid = 1'b0;
        check("midrst_nob", {axi.bvalid, axi.awready, axi.wready}, 3'b010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
